// File: rtl/ni_pkg.sv
// Shared types and helpers for the NoC network interface bridge.
// The state enums, tail flit constant and header field offsets live here so the
// TX and RX sides agree on the link format.
package ni_pkg;

    // TX packetiser states
    typedef enum logic [1:0] {
        TIdle,
        THead,
        TBody,
        TTail
    } tx_state_e;

    // RX depacketiser states
    typedef enum logic [1:0] {
        RHead,
        RBody,
        RTail,
        ROut
    } rx_state_e;

    // Tail flit is all ones; modules truncate this to their FLIT_W.
    localparam int unsigned MaxFlitW = 64;
    localparam logic [MaxFlitW-1:0] TailFlit = '1;

    // Number of payload flits per processor word
    function automatic int unsigned calc_nf(input int unsigned data_w, input int unsigned flit_w);
        return data_w / flit_w;
    endfunction

    // Width of the header length field (must hold 0..NF)
    function automatic int unsigned calc_len_w(input int unsigned nf);
        return $clog2(nf + 1);
    endfunction

    // Header layout: {tag, len, dest} from MSB to LSB
    function automatic int unsigned hdr_len_lsb(input int unsigned addr_w);
        return addr_w;
    endfunction

    function automatic int unsigned hdr_tag_lsb(input int unsigned addr_w,
                                                input int unsigned len_w);
        return addr_w + len_w;
    endfunction

endpackage

// File: rtl/ni_rx_depack.sv
// RX depacketiser: reassembles header/payload/tail flits into one processor word.
// Packets for other nodes are consumed and dropped; framing problems (bad tag,
// oversize length, bad tail) are flagged on rx_err with the delivered word.
module ni_rx_depack
    import ni_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned FLIT_W  = 8,
    parameter int unsigned ADDR_W  = 2,
    parameter int unsigned NODE_ID = 0,
    parameter int unsigned HDR_TAG = 5,
    localparam int unsigned NF     = calc_nf(DATA_W, FLIT_W),
    localparam int unsigned LEN_W  = calc_len_w(NF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FLIT_W-1:0] noc_in_flit,
    input  logic              noc_in_valid,
    output logic              noc_in_ready,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic [LEN_W-1:0]  rx_len,
    output logic              rx_err
);

    localparam int unsigned LenLsb = hdr_len_lsb(ADDR_W);
    localparam int unsigned TagLsb = hdr_tag_lsb(ADDR_W, LEN_W);
    localparam int unsigned TagW   = FLIT_W - TagLsb;
    localparam logic [TagW-1:0]   Tag  = TagW'(HDR_TAG);
    localparam logic [FLIT_W-1:0] Tail = TailFlit[FLIT_W-1:0];

    rx_state_e rx_state_q, rx_state_d;

    logic [DATA_W-1:0] buf_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  cnt_q;
    logic              err_q;
    logic              match_q;

    logic [TagW-1:0]   hdr_tag;
    logic [LEN_W-1:0]  hdr_len;
    logic [ADDR_W-1:0] hdr_dest;
    logic              len_over;
    logic [LEN_W-1:0]  len_clamp;
    logic              in_hs;

    assign hdr_tag   = noc_in_flit[FLIT_W-1:TagLsb];
    assign hdr_len   = noc_in_flit[TagLsb-1:LenLsb];
    assign hdr_dest  = noc_in_flit[ADDR_W-1:0];
    assign len_over  = hdr_len > LEN_W'(NF);
    assign len_clamp = len_over ? LEN_W'(NF) : hdr_len;
    assign in_hs     = noc_in_valid && noc_in_ready;

    assign rx_data = buf_q;
    assign rx_len  = len_q;
    assign rx_err  = err_q;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state_q <= RHead;
        end else begin
            rx_state_q <= rx_state_d;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        rx_state_d   = rx_state_q;
        noc_in_ready = 1'b1;
        rx_valid     = 1'b0;
        unique case (rx_state_q)
            RHead: begin
                if (noc_in_valid) begin
                    rx_state_d = (len_clamp == '0) ? RTail : RBody;
                end
            end
            RBody: begin
                if (noc_in_valid && (cnt_q == len_q - LEN_W'(1))) begin
                    rx_state_d = RTail;
                end
            end
            RTail: begin
                if (noc_in_valid) begin
                    rx_state_d = match_q ? ROut : RHead;
                end
            end
            ROut: begin
                // Link stalls until the processor takes the word
                noc_in_ready = 1'b0;
                rx_valid     = 1'b1;
                if (rx_ready) begin
                    rx_state_d = RHead;
                end
            end
            default: rx_state_d = RHead;
        endcase
    end

    // Reassembly buffer, length, error and destination-match tracking
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_q   <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            match_q <= 1'b0;
        end else if (in_hs) begin
            case (rx_state_q)
                RHead: begin
                    buf_q   <= '0;
                    err_q   <= (hdr_tag != Tag) || len_over;
                    len_q   <= len_clamp;
                    cnt_q   <= '0;
                    match_q <= (hdr_dest == ADDR_W'(NODE_ID));
                end
                RBody: begin
                    for (int k = 0; k < NF; k++) begin
                        if (cnt_q == LEN_W'(k)) begin
                            buf_q[k*FLIT_W +: FLIT_W] <= noc_in_flit;
                        end
                    end
                    cnt_q <= cnt_q + LEN_W'(1);
                end
                RTail: begin
                    if (noc_in_flit != Tail) begin
                        err_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/ni_flit_bridge.sv
// Network interface between a processor valid/ready port and one NoC router port.
// TX packetises a word into header, payload (LS flit first) and all-ones tail flits;
// RX is handled by ni_rx_depack. The two paths share nothing but clock and reset.
// Build option: define NI_ZERO_TRIM_EN to drop trailing all-zero payload flits on TX.
module ni_flit_bridge
    import ni_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned FLIT_W  = 8,
    parameter int unsigned ADDR_W  = 2,
    parameter int unsigned NODE_ID = 0,
    parameter int unsigned HDR_TAG = 5,
    localparam int unsigned NF     = calc_nf(DATA_W, FLIT_W),
    localparam int unsigned LEN_W  = calc_len_w(NF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [ADDR_W-1:0] tx_dest,
    input  logic [DATA_W-1:0] tx_data,
    output logic [FLIT_W-1:0] noc_out_flit,
    output logic              noc_out_valid,
    output logic              noc_out_last,
    input  logic              noc_out_ready,
    input  logic [FLIT_W-1:0] noc_in_flit,
    input  logic              noc_in_valid,
    output logic              noc_in_ready,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic [LEN_W-1:0]  rx_len,
    output logic              rx_err
);

    localparam int unsigned TagW = FLIT_W - hdr_tag_lsb(ADDR_W, LEN_W);
    localparam logic [TagW-1:0]   Tag  = TagW'(HDR_TAG);
    localparam logic [FLIT_W-1:0] Tail = TailFlit[FLIT_W-1:0];

    tx_state_e tx_state_q, tx_state_d;

    logic [ADDR_W-1:0] dest_q;
    logic [DATA_W-1:0] data_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  idx_q;
    logic [LEN_W-1:0]  tx_len_calc;
    logic [FLIT_W-1:0] body_flit;
    logic [FLIT_W-1:0] head_flit;

`ifdef NI_ZERO_TRIM_EN
    // Length = highest non-zero payload flit + 1, never less than one flit
    always_comb begin
        tx_len_calc = LEN_W'(1);
        for (int k = 1; k < NF; k++) begin
            if (tx_data[k*FLIT_W +: FLIT_W] != '0) begin
                tx_len_calc = LEN_W'(k + 1);
            end
        end
    end
`else
    assign tx_len_calc = LEN_W'(NF);
`endif

    assign head_flit = {Tag, len_q, dest_q};

    // Payload flit mux, least-significant flit first
    always_comb begin
        body_flit = '0;
        for (int k = 0; k < NF; k++) begin
            if (idx_q == LEN_W'(k)) begin
                body_flit = data_q[k*FLIT_W +: FLIT_W];
            end
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state_q <= TIdle;
        end else begin
            tx_state_q <= tx_state_d;
        end
    end

    // Next-state and link outputs; flit is a pure function of registered state,
    // so it stays stable while the router stalls.
    always_comb begin
        tx_state_d    = tx_state_q;
        tx_ready      = 1'b0;
        noc_out_valid = 1'b0;
        noc_out_last  = 1'b0;
        noc_out_flit  = '0;
        unique case (tx_state_q)
            TIdle: begin
                tx_ready = 1'b1;
                if (tx_valid) begin
                    tx_state_d = THead;
                end
            end
            THead: begin
                noc_out_valid = 1'b1;
                noc_out_flit  = head_flit;
                if (noc_out_ready) begin
                    tx_state_d = TBody;
                end
            end
            TBody: begin
                noc_out_valid = 1'b1;
                noc_out_flit  = body_flit;
                if (noc_out_ready && (idx_q == len_q - LEN_W'(1))) begin
                    tx_state_d = TTail;
                end
            end
            TTail: begin
                noc_out_valid = 1'b1;
                noc_out_last  = 1'b1;
                noc_out_flit  = Tail;
                if (noc_out_ready) begin
                    tx_state_d = TIdle;
                end
            end
            default: tx_state_d = TIdle;
        endcase
    end

    // Word capture and payload flit index
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dest_q <= '0;
            data_q <= '0;
            len_q  <= '0;
            idx_q  <= '0;
        end else if (tx_state_q == TIdle && tx_valid) begin
            dest_q <= tx_dest;
            data_q <= tx_data;
            len_q  <= tx_len_calc;
            idx_q  <= '0;
        end else if (tx_state_q == TBody && noc_out_ready) begin
            idx_q <= idx_q + LEN_W'(1);
        end
    end

    ni_rx_depack #(
        .DATA_W  (DATA_W),
        .FLIT_W  (FLIT_W),
        .ADDR_W  (ADDR_W),
        .NODE_ID (NODE_ID),
        .HDR_TAG (HDR_TAG)
    ) u_rx (
        .clk          (clk),
        .rst          (rst),
        .noc_in_flit  (noc_in_flit),
        .noc_in_valid (noc_in_valid),
        .noc_in_ready (noc_in_ready),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .rx_data      (rx_data),
        .rx_len       (rx_len),
        .rx_err       (rx_err)
    );

endmodule

// File: tb/tb_ni_flit_bridge.sv
// Directed bench for ni_flit_bridge with NODE_ID = 1 and default widths.
// Header = {tag 3'b101, len[2:0], dest[1:0]}; tail = 8'hFF.
module tb_ni_flit_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        tx_valid;
    logic        tx_ready;
    logic [1:0]  tx_dest;
    logic [31:0] tx_data;
    logic [7:0]  noc_out_flit;
    logic        noc_out_valid;
    logic        noc_out_last;
    logic        noc_out_ready;
    logic [7:0]  noc_in_flit;
    logic        noc_in_valid;
    logic        noc_in_ready;
    logic        rx_valid;
    logic        rx_ready;
    logic [31:0] rx_data;
    logic [2:0]  rx_len;
    logic        rx_err;

    int errors = 0;
    int checks = 0;

    logic [7:0] exp_flits [0:5];
    int         n_a5;

    always #5 clk = ~clk;

    ni_flit_bridge #(
        .DATA_W  (32),
        .FLIT_W  (8),
        .ADDR_W  (2),
        .NODE_ID (1),
        .HDR_TAG (5)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .tx_dest       (tx_dest),
        .tx_data       (tx_data),
        .noc_out_flit  (noc_out_flit),
        .noc_out_valid (noc_out_valid),
        .noc_out_last  (noc_out_last),
        .noc_out_ready (noc_out_ready),
        .noc_in_flit   (noc_in_flit),
        .noc_in_valid  (noc_in_valid),
        .noc_in_ready  (noc_in_ready),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready),
        .rx_data       (rx_data),
        .rx_len        (rx_len),
        .rx_err        (rx_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Send one word and check every flit against exp_flits[0:n-1].
    // With stall set, each flit is first shown for a cycle with ready low.
    task automatic tx_run(input logic [31:0] data, input logic [1:0] dest, input int n,
                          input bit stall);
        tx_valid      = 1'b1;
        tx_data       = data;
        tx_dest       = dest;
        noc_out_ready = 1'b1;
        chk("tx_ready_idle", tx_ready, 1);
        @(negedge clk);
        tx_valid = 1'b0;
        chk("tx_ready_busy", tx_ready, 0);
        for (int i = 0; i < n; i++) begin
            if (stall) begin
                noc_out_ready = 1'b0;
                chk("stall_valid", noc_out_valid, 1);
                chk("stall_flit", noc_out_flit, exp_flits[i]);
                @(negedge clk);
                noc_out_ready = 1'b1;
            end
            chk("flit_valid", noc_out_valid, 1);
            chk("flit", noc_out_flit, exp_flits[i]);
            chk("flit_last", noc_out_last, (i == n - 1) ? 1 : 0);
            @(negedge clk);
        end
        chk("tx_ready_after", tx_ready, 1);
        chk("out_valid_after", noc_out_valid, 0);
    endtask

    task automatic rx_flit(input logic [7:0] f);
        noc_in_flit  = f;
        noc_in_valid = 1'b1;
        chk("in_ready", noc_in_ready, 1);
        @(negedge clk);
        noc_in_valid = 1'b0;
    endtask

    task automatic rx_take();
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        chk("rx_valid_clr", rx_valid, 0);
        chk("in_ready_back", noc_in_ready, 1);
    endtask

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst           = 1'b1;
        tx_valid      = 1'b0;
        tx_dest       = '0;
        tx_data       = '0;
        noc_out_ready = 1'b0;
        noc_in_flit   = '0;
        noc_in_valid  = 1'b0;
        rx_ready      = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset values
        chk("rst_tx_ready", tx_ready, 1);
        chk("rst_out_valid", noc_out_valid, 0);
        chk("rst_out_last", noc_out_last, 0);
        chk("rst_out_flit", noc_out_flit, 0);
        chk("rst_in_ready", noc_in_ready, 1);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_rx_err", rx_err, 0);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_rx_len", rx_len, 0);

        // TX 0x000000A5 to dest 1, ready high
`ifdef NI_ZERO_TRIM_EN
        exp_flits = '{8'hA5, 8'hA5, 8'hFF, 8'h00, 8'h00, 8'h00};
        n_a5      = 3;
`else
        exp_flits = '{8'hB1, 8'hA5, 8'h00, 8'h00, 8'h00, 8'hFF};
        n_a5      = 6;
`endif
        tx_run(32'h0000_00A5, 2'd1, n_a5, 1'b0);

        // TX 0x11223344 to dest 2 with ready toggling
        exp_flits = '{8'hB2, 8'h44, 8'h33, 8'h22, 8'h11, 8'hFF};
        tx_run(32'h1122_3344, 2'd2, 6, 1'b1);

        // RX all-ones payload; processor holds off for 5 cycles
        rx_flit(8'hB1);
        for (int i = 0; i < 5; i++) rx_flit(8'hFF);
        for (int i = 0; i < 5; i++) begin
            chk("ones_valid", rx_valid, 1);
            chk("ones_data", rx_data, 32'hFFFF_FFFF);
            chk("ones_len", rx_len, 4);
            chk("ones_err", rx_err, 0);
            chk("ones_in_stall", noc_in_ready, 0);
            @(negedge clk);
        end
        rx_take();

        // Packet for dest 2 is dropped
        rx_flit(8'hA6);
        rx_flit(8'h12);
        rx_flit(8'hFF);
        chk("drop_no_valid", rx_valid, 0);
        @(negedge clk);
        chk("drop_no_valid2", rx_valid, 0);

        // Bad tail flags err
        rx_flit(8'hA5);
        rx_flit(8'h34);
        rx_flit(8'h00);
        chk("badtail_valid", rx_valid, 1);
        chk("badtail_data", rx_data, 32'h0000_0034);
        chk("badtail_len", rx_len, 1);
        chk("badtail_err", rx_err, 1);
        rx_take();

        // Oversize length (7) clamps to 4 and flags err
        rx_flit(8'hBD);
        rx_flit(8'h01);
        rx_flit(8'h02);
        rx_flit(8'h03);
        rx_flit(8'h04);
        rx_flit(8'hFF);
        chk("clamp_valid", rx_valid, 1);
        chk("clamp_data", rx_data, 32'h0403_0201);
        chk("clamp_len", rx_len, 4);
        chk("clamp_err", rx_err, 1);
        rx_take();

        // Zero-length packet goes straight to the tail
        rx_flit(8'hA1);
        rx_flit(8'hFF);
        chk("zero_valid", rx_valid, 1);
        chk("zero_data", rx_data, 0);
        chk("zero_len", rx_len, 0);
        chk("zero_err", rx_err, 0);
        rx_take();

        // Wrong tag flags err but still delivers
        rx_flit(8'h65);
        rx_flit(8'h77);
        rx_flit(8'hFF);
        chk("tag_valid", rx_valid, 1);
        chk("tag_data", rx_data, 32'h0000_0077);
        chk("tag_err", rx_err, 1);
        rx_take();

        // Reset during TX payload flit 2
        tx_valid      = 1'b1;
        tx_data       = 32'h1122_3344;
        tx_dest       = 2'd1;
        noc_out_ready = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        chk("mid_head", noc_out_flit, 8'hB1);
        @(negedge clk);
        chk("mid_p0", noc_out_flit, 8'h44);
        @(negedge clk);
        chk("mid_p1", noc_out_flit, 8'h33);
        @(negedge clk);
        chk("mid_p2", noc_out_flit, 8'h22);
        rst = 1'b1;
        #1;
        chk("arst_tx_ready", tx_ready, 1);
        chk("arst_out_valid", noc_out_valid, 0);
        chk("arst_out_last", noc_out_last, 0);
        chk("arst_out_flit", noc_out_flit, 0);
        chk("arst_in_ready", noc_in_ready, 1);
        chk("arst_rx_valid", rx_valid, 0);
        chk("arst_rx_data", rx_data, 0);
        chk("arst_rx_len", rx_len, 0);
        chk("arst_rx_err", rx_err, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
`ifdef NI_ZERO_TRIM_EN
        exp_flits = '{8'hA5, 8'hA5, 8'hFF, 8'h00, 8'h00, 8'h00};
`else
        exp_flits = '{8'hB1, 8'hA5, 8'h00, 8'h00, 8'h00, 8'hFF};
`endif
        tx_run(32'h0000_00A5, 2'd1, n_a5, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
